// File: rtl/dmem_wbuf_ram_if.sv
// Purpose: load/store port bundle between the pipeline and the data-memory responder.
// Latency: n/a (wires only).
// Backpressure: stall_o from the responder holds both read and write requests.
// Ports: read request/address in, registered read data/valid out; write request/address/data in;
//        stall, buffer-empty and sticky overflow status out.
interface dmem_wbuf_ram_if;
  logic        mem_rena_i;
  logic [31:0] mem_raddr_i;
  logic [31:0] mem_rdata_o;
  logic        mem_rvalid_o;
  logic        mem_wena_i;
  logic [31:0] mem_waddr_i;
  logic [31:0] mem_wdata_i;
  logic        stall_o;
  logic        wbuf_empty_o;
  logic        overflow_o;

  // Pipeline side.
  modport master (
    output mem_rena_i, mem_raddr_i, mem_wena_i, mem_waddr_i, mem_wdata_i,
    input  mem_rdata_o, mem_rvalid_o, stall_o, wbuf_empty_o, overflow_o
  );

  // Memory responder side.
  modport slave (
    input  mem_rena_i, mem_raddr_i, mem_wena_i, mem_waddr_i, mem_wdata_i,
    output mem_rdata_o, mem_rvalid_o, stall_o, wbuf_empty_o, overflow_o
  );
endinterface

// File: rtl/dmem_wbuf_ram.sv
// Purpose: data-memory responder; in-order write buffer draining into a single-port word RAM, with load forwarding.
// Latency: reads return 1 cycle after being served; writes land in the RAM whenever a cycle has no read.
// Backpressure: stall_o when the buffer is full; that cycle forces a drain, skips the read and drops the write.
// Ports: clk, arst_n (async active-low); bus = slave side of dmem_wbuf_ram_if
//        (read req/addr -> rdata/rvalid, write req/addr/data, stall/wbuf_empty/overflow status).
module dmem_wbuf_ram #(
  parameter int MEM_AW     = 12,
  parameter int WBUF_DEPTH = 4
) (
  input  logic           clk,
  input  logic           arst_n,
  dmem_wbuf_ram_if.slave bus
);

  localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [MEM_AW-1:0] addr;
    logic [31:0]       dat;
  } wb_ent_t;

  logic [31:0]       ram [2**MEM_AW];
  wb_ent_t           wbuf [WBUF_DEPTH];

  logic [PW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q;
  logic [31:0]       rdata_q;
  logic              rvalid_q;
  logic              ovf_q;

  logic [MEM_AW-1:0] raddr_w, waddr_w;
  logic              full, drain, rd_srv, push;
  logic              fwd_hit;
  logic [31:0]       fwd_dat, rd_dat;
  logic [PW-1:0]     idx;

  // Byte-offset bits and everything above the array size are ignored, so addresses alias.
  assign raddr_w = bus.mem_raddr_i[MEM_AW+1:2];
  assign waddr_w = bus.mem_waddr_i[MEM_AW+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.mem_raddr_i[31:MEM_AW+2], bus.mem_raddr_i[1:0],
                              bus.mem_waddr_i[31:MEM_AW+2], bus.mem_waddr_i[1:0]};

  // A full buffer owns the RAM port; otherwise reads win and drains take idle cycles.
  assign full   = (count_q == CW'(WBUF_DEPTH));
  assign rd_srv = !full && bus.mem_rena_i;
  assign drain  = full || (!bus.mem_rena_i && (count_q != '0));
  assign push   = !full && bus.mem_wena_i;

  // Scan oldest to newest so the newest matching entry overrides older duplicates.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_dat = '0;
    idx     = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (wbuf[idx].addr == raddr_w)) begin
        fwd_hit = 1'b1;
        fwd_dat = wbuf[idx].dat;
      end
    end
  end

  // A write accepted in the same cycle is younger than anything already buffered.
  always_comb begin
    rd_dat = ram[raddr_w];
    if (fwd_hit) rd_dat = fwd_dat;
    if (push && (waddr_w == raddr_w)) rd_dat = bus.mem_wdata_i;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      rvalid_q <= rd_srv;
      if (rd_srv) rdata_q <= rd_dat;
      if (push)   tail_q  <= tail_q + 1'b1;
      if (drain)  head_q  <= head_q + 1'b1;
      case ({push, drain})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (full && bus.mem_wena_i) ovf_q <= 1'b1;
    end
  end

  // Storage arrays carry no reset; count_q alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) wbuf[tail_q] <= '{addr: waddr_w, dat: bus.mem_wdata_i};
  end

  always_ff @(posedge clk) begin
    if (drain) ram[wbuf[head_q].addr] <= wbuf[head_q].dat;
  end

  assign bus.mem_rdata_o  = rdata_q;
  assign bus.mem_rvalid_o = rvalid_q;
  assign bus.stall_o      = full;
  assign bus.wbuf_empty_o = (count_q == '0);
  assign bus.overflow_o   = ovf_q;

endmodule

// File: tb/tb_dmem_wbuf_ram.sv
// Purpose: directed bench for dmem_wbuf_ram; read results checked by a scoreboard monitor.
// Latency: expected read data queued when a served read is issued, popped when rvalid appears.
// Backpressure: stall/overflow/empty status checked directly from the stimulus thread.
module tb_dmem_wbuf_ram;

  logic clk;
  logic arst_n;
  int   checks;
  int   errors;
  logic [31:0] exp_q [$];

  dmem_wbuf_ram_if bus ();

  dmem_wbuf_ram #(.MEM_AW(12), .WBUF_DEPTH(4)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic put(input logic re, input logic [31:0] ra,
                     input logic we, input logic [31:0] wa, input logic [31:0] wd,
                     input logic srv, input logic [31:0] exp);
    bus.mem_rena_i  = re;
    bus.mem_raddr_i = ra;
    bus.mem_wena_i  = we;
    bus.mem_waddr_i = wa;
    bus.mem_wdata_i = wd;
    if (srv) exp_q.push_back(exp);
  endtask

  // Drive one cycle's inputs at a falling edge and return at the next falling edge.
  task automatic cyc(input logic re, input logic [31:0] ra,
                     input logic we, input logic [31:0] wa, input logic [31:0] wd,
                     input logic srv, input logic [31:0] exp);
    put(re, ra, we, wa, wd, srv, exp);
    nxt();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Scoreboard monitor: every valid read result must match the oldest queued expectation.
  always @(negedge clk) begin
    if (arst_n && bus.mem_rvalid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got rvalid with data %h, required no read pending", bus.mem_rdata_o);
      end else begin
        chk("rd_data", bus.mem_rdata_o, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    arst_n = 1'b0;
    put(0, 0, 0, 0, 0, 0, 0);
    nxt();
    nxt();
    chk("rst_rvalid", {31'b0, bus.mem_rvalid_o}, 0);
    chk("rst_rdata",  bus.mem_rdata_o, 0);
    chk("rst_stall",  {31'b0, bus.stall_o}, 0);
    chk("rst_empty",  {31'b0, bus.wbuf_empty_o}, 1);
    chk("rst_ovf",    {31'b0, bus.overflow_o}, 0);
    arst_n = 1'b1;

    // Store then drain, then load from RAM.
    cyc(0, 0, 1, 32'h100, 32'hDEADBEEF, 0, 0);
    chk("t1_pending", {31'b0, bus.wbuf_empty_o}, 0);
    idle(3);
    chk("t1_empty", {31'b0, bus.wbuf_empty_o}, 1);
    cyc(1, 32'h100, 0, 0, 0, 1, 32'hDEADBEEF);

    // Same-cycle forwarding and newest-entry forwarding.
    cyc(1, 32'h40, 1, 32'h40, 32'h11223344, 1, 32'h11223344);
    cyc(1, 32'h44, 1, 32'h44, 32'h0000000A, 1, 32'h0000000A);
    cyc(1, 32'h44, 1, 32'h44, 32'h0000000B, 1, 32'h0000000B);
    cyc(1, 32'h44, 0, 0, 0, 1, 32'h0000000B);
    chk("t2_pending", {31'b0, bus.wbuf_empty_o}, 0);
    idle(3);
    chk("t2_empty", {31'b0, bus.wbuf_empty_o}, 1);
    cyc(1, 32'h44, 0, 0, 0, 1, 32'h0000000B);
    cyc(1, 32'h40, 0, 0, 0, 1, 32'h11223344);

    // Aliasing above the array size and in the byte-offset bits.
    cyc(0, 0, 1, 32'h0, 32'h00000055, 0, 0);
    idle(1);
    chk("t5_empty", {31'b0, bus.wbuf_empty_o}, 1);
    cyc(1, 32'h4000, 0, 0, 0, 1, 32'h00000055);
    cyc(1, 32'h3, 0, 0, 0, 1, 32'h00000055);

    // Reads starve draining until full; the full cycle drains, skips the read, drops the write.
    cyc(1, 32'h0, 1, 32'h10, 32'h10100001, 1, 32'h00000055);
    cyc(1, 32'h0, 1, 32'h14, 32'h14140002, 1, 32'h00000055);
    cyc(1, 32'h0, 1, 32'h18, 32'h18180003, 1, 32'h00000055);
    chk("t3_stall_3", {31'b0, bus.stall_o}, 0);
    cyc(1, 32'h0, 1, 32'h1C, 32'h1C1C0004, 1, 32'h00000055);
    chk("t3_stall_4", {31'b0, bus.stall_o}, 1);
    chk("t3_ovf_pre", {31'b0, bus.overflow_o}, 0);
    cyc(1, 32'h0, 1, 32'h10, 32'h0BAD0BAD, 0, 0);
    chk("t3_stall_clr", {31'b0, bus.stall_o}, 0);
    chk("t4_ovf_set",   {31'b0, bus.overflow_o}, 1);
    chk("t3_rvalid_0",  {31'b0, bus.mem_rvalid_o}, 0);
    chk("t3_rdata_hold", bus.mem_rdata_o, 32'h00000055);
    chk("t3_pending",   {31'b0, bus.wbuf_empty_o}, 0);
    cyc(1, 32'h10, 0, 0, 0, 1, 32'h10100001);
    cyc(1, 32'h1C, 0, 0, 0, 1, 32'h1C1C0004);
    idle(3);
    chk("t4_empty", {31'b0, bus.wbuf_empty_o}, 1);
    cyc(1, 32'h14, 0, 0, 0, 1, 32'h14140002);
    cyc(1, 32'h18, 0, 0, 0, 1, 32'h18180003);
    chk("t4_ovf_sticky", {31'b0, bus.overflow_o}, 1);

    // Reset with two undrained entries: they are discarded, RAM keeps older data.
    cyc(0, 0, 1, 32'h200, 32'h11111111, 0, 0);
    cyc(0, 0, 1, 32'h204, 32'h22222222, 0, 0);
    idle(3);
    chk("t6_empty_pre", {31'b0, bus.wbuf_empty_o}, 1);
    cyc(1, 32'h0, 1, 32'h200, 32'h99999999, 1, 32'h00000055);
    cyc(1, 32'h0, 1, 32'h204, 32'hAAAAAAAA, 1, 32'h00000055);
    chk("t6_rvalid_pre", {31'b0, bus.mem_rvalid_o}, 1);
    chk("t6_pending",    {31'b0, bus.wbuf_empty_o}, 0);
    put(0, 0, 0, 0, 0, 0, 0);
    #2 arst_n = 1'b0;
    #1;
    chk("t6_rvalid_async", {31'b0, bus.mem_rvalid_o}, 0);
    chk("t6_empty_async",  {31'b0, bus.wbuf_empty_o}, 1);
    chk("t6_stall_async",  {31'b0, bus.stall_o}, 0);
    chk("t6_ovf_async",    {31'b0, bus.overflow_o}, 0);
    chk("t6_rdata_async",  bus.mem_rdata_o, 0);
    nxt();
    nxt();
    arst_n = 1'b1;
    cyc(1, 32'h200, 0, 0, 0, 1, 32'h11111111);
    cyc(1, 32'h204, 0, 0, 0, 1, 32'h22222222);
    idle(3);
    chk("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
